// File: rtl/mfp_ahb_timer_bank.sv
// mfp_ahb_timer_bank: AHB-Lite slave holding NUM_CH programmable interval
// timers that share one prescaler. Each channel has sticky expired/overrun
// flags (write-1-to-clear), an optional one-shot mode and its own irq line.
module mfp_ahb_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [6:0]        HADDR,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic [NUM_CH-1:0] irq
);

  // Handshake: an address phase is accepted (valid) only when
  // HSEL & HTRANS[1] & HREADY; the slave is always ready (HREADYOUT=1), so
  // every accepted transfer completes in the single following data phase.
  logic       a_valid_q, a_valid_d;
  logic       a_write_q, a_write_d;
  logic [4:0] a_word_q, a_word_d;
  logic [2:0] a_ch;
  logic [1:0] a_reg;
  logic       wr_en, rd_en, glb_sel, pre_wr, tick;

  logic [NUM_CH-1:0] en_q, en_d, oneshot_q, oneshot_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] expired_q, expired_d, overrun_q, overrun_d;
  logic [NUM_CH-1:0] ctrl_wr, period_wr, status_wr, cnt_clr, fire;
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [PRE_W-1:0]  prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;

  // Write data bits above the register widths and the byte-lane address bits
  // carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{HWDATA, HADDR[1:0], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign a_ch      = a_word_q[4:2];
  assign a_reg     = a_word_q[1:0];
  assign wr_en     = a_valid_q & a_write_q;
  assign rd_en     = a_valid_q & ~a_write_q;
  // With 8 channels the global page would sit beyond the 7-bit address space.
  assign glb_sel   = (NUM_CH < 8) && (a_ch == 3'(NUM_CH));
  assign pre_wr    = wr_en & glb_sel & (a_reg == 2'd1);
  assign tick      = (pre_cnt_q == prescale_q);
  assign irq       = expired_q & irq_en_q;

  // Address-phase capture; the data phase uses only these registered copies.
  always_comb begin
    a_valid_d = HSEL & HTRANS[1] & HREADY;
    a_write_d = a_write_q;
    a_word_d  = a_word_q;
    if (a_valid_d) begin
      a_write_d = HWRITE;
      a_word_d  = HADDR[6:2];
    end
  end

  // Address-phase registers; reset drops any pending data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_word_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_write_q <= a_write_d;
      a_word_q  <= a_word_d;
    end
  end

  // Shared prescaler: tick when pre_cnt reaches PRESCALE; a PRESCALE write restarts it.
  always_comb begin
    prescale_d = pre_wr ? HWDATA[PRE_W-1:0] : prescale_q;
    pre_cnt_d  = (pre_wr || tick) ? '0 : pre_cnt_q + PRE_W'(1);
  end

  // Prescaler registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  // Per-channel write strobes and expiry events; a counter clear suppresses that cycle's tick.
  always_comb begin
    ctrl_wr   = '0;
    period_wr = '0;
    status_wr = '0;
    cnt_clr   = '0;
    fire      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_wr[i]   = wr_en && (a_ch == 3'(i)) && (a_reg == 2'd0);
      period_wr[i] = wr_en && (a_ch == 3'(i)) && (a_reg == 2'd1);
      status_wr[i] = wr_en && (a_ch == 3'(i)) && (a_reg == 2'd3);
      cnt_clr[i]   = period_wr[i] | (ctrl_wr[i] & HWDATA[3]);
      fire[i]      = tick & en_q[i] & (count_q[i] == period_q[i]) & ~cnt_clr[i];
    end
  end

  // Channel next state: W1C clears are applied first so a same-cycle expiry wins.
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
    overrun_d = overrun_q;
    period_d  = period_q;
    count_d   = count_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (status_wr[i] && HWDATA[0]) expired_d[i] = 1'b0;
      if (status_wr[i] && HWDATA[1]) overrun_d[i] = 1'b0;
      if (ctrl_wr[i]) begin
        en_d[i]      = HWDATA[0];
        oneshot_d[i] = HWDATA[1];
        irq_en_d[i]  = HWDATA[2];
      end
      if (period_wr[i]) period_d[i] = HWDATA[CNT_W-1:0];
      if (cnt_clr[i]) begin
        count_d[i] = '0;
      end else if (tick && en_q[i]) begin
        count_d[i] = fire[i] ? '0 : count_q[i] + CNT_W'(1);
      end
      if (fire[i]) begin
        expired_d[i] = 1'b1;
        if (expired_q[i]) overrun_d[i] = 1'b1;
        if (oneshot_q[i] && !ctrl_wr[i]) en_d[i] = 1'b0;
      end
    end
  end

  // Channel registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q      <= '0;
      oneshot_q <= '0;
      irq_en_q  <= '0;
      expired_q <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      expired_q <= expired_d;
      overrun_q <= overrun_d;
      period_q  <= period_d;
      count_q   <= count_d;
    end
  end

  // Read mux driven from the registered address; zero when no read is pending.
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (a_ch == 3'(i)) begin
          case (a_reg)
            2'd0:    HRDATA = {29'b0, irq_en_q[i], oneshot_q[i], en_q[i]};
            2'd1:    HRDATA = 32'(period_q[i]);
            2'd2:    HRDATA = 32'(count_q[i]);
            default: HRDATA = {30'b0, overrun_q[i], expired_q[i]};
          endcase
        end
      end
      if (glb_sel) begin
        case (a_reg)
          2'd0:    HRDATA = 32'(irq);
          2'd1:    HRDATA = 32'(prescale_q);
          default: HRDATA = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_timer_bank.sv
// Directed bench for mfp_ahb_timer_bank (NUM_CH=4): reset, periodic,
// prescale/overrun, one-shot, set/clear collision and address decode.
module tb_mfp_ahb_timer_bank;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT;
  logic [1:0]  HTRANS;
  logic [6:0]  HADDR;
  logic [31:0] HWDATA, HRDATA;
  logic [3:0]  irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  mfp_ahb_timer_bank #(.NUM_CH(4), .CNT_W(32), .PRE_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HADDR(HADDR), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .irq(irq)
  );

  // Clock and watchdog
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Driver tasks; all are called and return at a negative clock edge.
  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic ahb_write(input logic [6:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HREADY = 1'b1;
    @(negedge HCLK);
    bus_idle();
    HWDATA = d;
  endtask

  task automatic ahb_read(input logic [6:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HREADY = 1'b1;
    @(negedge HCLK);
    bus_idle();
    d = HRDATA;
  endtask

  task automatic expect_read(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    ahb_read(a, got);
    check(tag, got, exp_q.pop_front());
  endtask

  // Negedges until irq[b] is seen, bounded; returns the bound on timeout.
  task automatic wait_irq(input int b, output int k);
    k = 0;
    while (k < 60) begin
      @(negedge HCLK);
      k++;
      if (irq[b]) break;
    end
  endtask

  task automatic do_reset();
    bus_idle();
    HRESETn = 1'b0;
    cycles(2);
    HRESETn = 1'b1;
  endtask

  initial begin
    int k;
    HRESETn = 1'b0; HREADY = 1'b1; HWDATA = '0;
    bus_idle();
    cycles(3);
    HRESETn = 1'b1;

    // Reset mid-count and mid-transfer
    ahb_write(7'h44, 32'd1);
    ahb_write(7'h04, 32'd100);
    ahb_write(7'h00, 32'h5);
    cycles(10);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 7'h14;
    @(negedge HCLK);
    bus_idle();
    HWDATA = 32'h55;
    #2 HRESETn = 1'b0;
    cycles(2);
    HRESETn = 1'b1;
    check("rst_irq", {28'b0, irq}, 32'h0);
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("rst_hrdata_idle", HRDATA, 32'h0);
    for (int a = 0; a < 20; a++)
      expect_read($sformatf("rst_reg_%02h", a * 4), 7'(a * 4), 32'h0);

    // Periodic: PERIOD=3, irq_en, prescale 0
    ahb_write(7'h04, 32'd3);
    ahb_write(7'h00, 32'h5);
    wait_irq(0, k);
    check("per_irq_latency", 32'(k), 32'd5);
    expect_read("per_status", 7'h0C, 32'h1);
    ahb_write(7'h0C, 32'h1);
    cycles(1);
    check("per_w1c_irq_low", {31'b0, irq[0]}, 32'h0);
    cycles(1);
    check("per_reexpire_irq", {31'b0, irq[0]}, 32'h1);
    expect_read("per_status2", 7'h0C, 32'h1);
    ahb_write(7'h00, 32'h0);
    expect_read("per_count_hold", 7'h08, 32'd3);
    do_reset();

    // Prescale 2, ch1 PERIOD=1, overrun without clearing
    ahb_write(7'h44, 32'd2);
    ahb_write(7'h14, 32'd1);
    cycles(1);
    ahb_write(7'h10, 32'h5);
    wait_irq(1, k);
    check("pre_first_expiry", 32'(k), 32'd7);
    cycles(4);
    expect_read("pre_status_before", 7'h1C, 32'h1);
    expect_read("pre_status_overrun", 7'h1C, 32'h3);
    expect_read("pre_irq_pend", 7'h40, 32'h2);
    do_reset();

    // One-shot on ch2
    ahb_write(7'h24, 32'd5);
    ahb_write(7'h20, 32'h3);
    cycles(20);
    expect_read("os_ctrl", 7'h20, 32'h2);
    expect_read("os_status", 7'h2C, 32'h1);
    expect_read("os_count", 7'h28, 32'h0);
    check("os_irq_masked", {28'b0, irq}, 32'h0);
    do_reset();

    // Collision: W1C commits on the expiry edge; PERIOD write on a tick
    ahb_write(7'h04, 32'd3);
    ahb_write(7'h00, 32'h5);
    cycles(7);
    ahb_write(7'h0C, 32'h1);
    cycles(1);
    check("coll_irq_kept", {31'b0, irq[0]}, 32'h1);
    expect_read("coll_status", 7'h0C, 32'h3);
    ahb_write(7'h04, 32'd10);
    expect_read("coll_period_count", 7'h08, 32'h0);
    do_reset();

    // Decode: IDLE, BUSY, HREADY low, unselected, unmapped
    ahb_write(7'h04, 32'd7);
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 7'h04;
    @(negedge HCLK);
    bus_idle(); HWDATA = 32'h55;
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 7'h04;
    @(negedge HCLK);
    bus_idle(); HWDATA = 32'h56;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 7'h04; HREADY = 1'b0;
    @(negedge HCLK);
    bus_idle(); HREADY = 1'b1; HWDATA = 32'h57;
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 7'h04;
    @(negedge HCLK);
    bus_idle(); HWDATA = 32'h58;
    expect_read("dec_period_kept", 7'h04, 32'd7);
    ahb_write(7'h48, 32'hFFFF_FFFF);
    expect_read("dec_unmapped_48", 7'h48, 32'h0);
    expect_read("dec_prescale_kept", 7'h44, 32'h0);
    expect_read("dec_unmapped_7c", 7'h7C, 32'h0);
    ahb_write(7'h04, 32'd0);
    ahb_write(7'h00, 32'h5);
    ahb_write(7'h10, 32'h1);
    ahb_write(7'h30, 32'h5);
    cycles(3);
    check("dec_irq_pattern", {28'b0, irq}, 32'h9);
    expect_read("dec_irq_pend", 7'h40, 32'h9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_timer_bank.md
# mfp_ahb_timer_bank

Multi-channel AHB-Lite timer peripheral that generalises the single-flag "time is up / acknowledge" counter slave into a bank of `NUM_CH` independent programmable interval timers. All channels share one prescaler. Each channel has sticky expiry and overrun flags, write-1-to-clear acknowledge, an optional one-shot mode, and a per-channel interrupt output. The block sits on the MFP AHB-Lite bus as a slave behind the address decoder, and its `irq` outputs feed the interrupt controller.

## Interface
- `NUM_CH`, 4: number of timer channels (1–8).
- `CNT_W`, 32: counter and period width (8–32); read data is zero-extended to 32 bits.
- `PRE_W`, 16: shared prescaler width.
- `HCLK` input 1: bus and timer clock.
- `HRESETn` input 1: asynchronous, active-low reset.
- `HSEL` input 1: slave select from the address decoder.
- `HTRANS` input 2: AHB transfer type; `HTRANS[1]`=1 means NONSEQ/SEQ.
- `HWRITE` input 1: 1 = write.
- `HADDR` input 7: byte address within the block; bits [1:0] are ignored.
- `HREADY` input 1: bus ready; the address phase is accepted only when this is high.
- `HWDATA` input 32: write data, sampled in the data phase.
- `HRDATA` output 32: read data, valid in the data phase.
- `HREADYOUT` output 1: tied to 1 (zero wait states).
- `irq` output NUM_CH: `irq[i] = expired[i] & irq_en[i]`.

## Operation
- Address map, with channel `i` at byte base `16*i`:
  - +0x0 CTRL (RW): bit0 `en`, bit1 `oneshot`, bit2 `irq_en`, bit3 `clr` (write-only, self-clearing, reads 0).
  - +0x4 PERIOD (RW).
  - +0x8 COUNT (RO).
  - +0xC STATUS (W1C): bit0 `expired`, bit1 `overrun`.
- Global registers:
  - `16*NUM_CH`+0x0 IRQ_PEND (RO): NUM_CH bits, equal to `irq`.
  - `16*NUM_CH`+0x4 PRESCALE (RW, PRE_W bits).
- Unmapped addresses read 0; writes to them are ignored.
- Bus handling:
  - Address phase: when `HSEL & HTRANS[1] & HREADY`, register `HADDR`, `HWRITE` and a valid bit.
  - Data phase: perform the write with `HWDATA`. Read data is driven combinationally from the registered address.
  - IDLE/BUSY transfers and unselected cycles cause no register change.
- Prescaler:
  - `pre_cnt` counts 0..PRESCALE. On reaching PRESCALE it produces a 1-cycle `tick` and returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - A PRESCALE write also clears `pre_cnt`.
- Channel behaviour on a tick with `en`=1:
  - If COUNT==PERIOD: COUNT←0 and `expired`←1.
  - If `expired` was already 1 at that point, `overrun`←1.
  - If `oneshot`=1, `en`←0 at that expiry.
  - Otherwise COUNT←COUNT+1.
- PERIOD=0 means expiry on every tick.
- With `en`=0, COUNT holds.
- A write to PERIOD, or a CTRL write with `clr`=1, sets COUNT←0 and takes priority over the tick in that cycle.
- Simultaneous hardware set and W1C clear of the same STATUS bit: set wins. The bit remains 1 and is not lost.
- Writing 0 to STATUS bits has no effect.

## Timing
- Reset values are all 0: CTRL, PERIOD, COUNT, STATUS, PRESCALE, `pre_cnt`, registered address/valid, `irq`. `HRDATA` is 0 while no valid read is pending. `HREADYOUT`=1 always.
- Write latency:
  - A register updates on the HCLK edge that ends the data phase.
  - The new value is visible to a read whose data phase is the next cycle.
  - A back-to-back write→read to the same address returns the new value (no stall).
- Counter timing:
  - COUNT changes on the edge following a `tick` cycle.
  - `expired` and `irq` assert 1 cycle after the tick where COUNT==PERIOD.
  - Period in HCLK cycles = (PERIOD+1)·(PRESCALE+1).
- COUNT reads return the pre-edge value of the data-phase cycle.
- Asynchronous reset mid-transfer aborts the pending data phase; no write is committed.

## Test plan
- Reset:
  - Stimulus: assert HRESETn=0 mid-count, then read every register.
  - Required response: all registers read 0; `irq`=0; `HREADYOUT`=1.
- Periodic mode:
  - Stimulus: ch0 PRESCALE=0, PERIOD=3, CTRL=0x5.
  - Required response: `irq[0]` rises 4 cycles after enable plus 1. STATUS reads 1. W1C 0x1 clears it, and it sets again 4 cycles later.
- Prescale and overrun:
  - Stimulus: PRESCALE=2, ch1 PERIOD=1, no clear.
  - Required response: first expiry after 6 cycles; STATUS=0x3 after 12 cycles.
- One-shot:
  - Stimulus: ch2 CTRL=0x3, PERIOD=5.
  - Required response: single expiry; CTRL reads 0x2; COUNT holds 0.
- Collision:
  - Stimulus: W1C of STATUS lands in the same cycle as a new expiry.
  - Required response: `expired` stays 1. Separately, a PERIOD write during a tick leaves COUNT=0.
- Decode:
  - Stimulus: IDLE transfer with HSEL=1 and HWRITE=1; write to an unmapped address.
  - Required response: no state change; the unmapped address reads 0. IRQ_PEND equals the OR-pattern of the enabled expired channels.
